// File: rtl/inst_realign.sv
// Fetch-word to instruction realigner: buffers 16-bit parcels and presents one aligned
// instruction per cycle. Define REALIGN_RVC_EN to enable compressed (16-bit) instruction support.
module inst_realign #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        fetch_valid_i,
  output logic        fetch_ready_o,
  input  logic [31:0] fetch_data_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic        is_compressed_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [15:0]   r_buf [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_head_pc;
  logic          r_skip_low;

  logic [PW-1:0] w_rd_ptr_p1;
  logic [PW-1:0] w_wr_ptr_p1;
  logic [15:0]   w_head;
  logic [15:0]   w_head_hi;
  logic          w_c;
  logic          w_valid;
  logic          w_push;
  logic          w_pop;
  logic [1:0]    w_push_n;
  logic [1:0]    w_pop_n;
  logic          w_unused;

  // Pointer advance modulo DEPTH; DEPTH need not be a power of two.
  function automatic logic [PW-1:0] f_adv(input logic [PW-1:0] p, input logic [1:0] n);
    int unsigned s;
    s = 32'(p) + 32'(n);
    if (s >= DEPTH) s = s - DEPTH;
    return PW'(s);
  endfunction

  assign w_rd_ptr_p1 = f_adv(r_rd_ptr, 2'd1);
  assign w_wr_ptr_p1 = f_adv(r_wr_ptr, 2'd1);
  assign w_head      = r_buf[r_rd_ptr];
  assign w_head_hi   = r_buf[w_rd_ptr_p1];

`ifdef REALIGN_RVC_EN
  assign w_c = (w_head[1:0] != 2'b11);
`else
  assign w_c = 1'b0;
`endif

  assign w_valid = (w_c  && (r_count >= CW'(1))) ||
                   (!w_c && (r_count >= CW'(2)));

  assign fetch_ready_o   = (r_count <= CW'(DEPTH - 2));
  assign out_valid_o     = w_valid;
  assign is_compressed_o = w_valid & w_c;
  assign inst_pc_o       = r_head_pc;

  always_comb begin
    inst_o = '0;
    if (w_valid) begin
      if (w_c) inst_o = {16'h0000, w_head};
      else     inst_o = {w_head_hi, w_head};
    end
  end

  // Flush suppresses both sides of the handshake in its cycle.
  assign w_push = fetch_valid_i & fetch_ready_o & ~flush_i;
  assign w_pop  = w_valid & out_ready_i & ~flush_i;

  always_comb begin
    w_push_n = 2'd0;
    if (w_push) w_push_n = r_skip_low ? 2'd1 : 2'd2;
  end

  always_comb begin
    w_pop_n = 2'd0;
    if (w_pop) w_pop_n = w_c ? 2'd1 : 2'd2;
  end

  assign w_unused = ^redirect_pc_i[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_buf[i] <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_head_pc  <= RESET_PC;
      r_skip_low <= 1'b0;
    end else if (flush_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
`ifdef REALIGN_RVC_EN
      r_head_pc  <= {redirect_pc_i[31:1], 1'b0};
      r_skip_low <= redirect_pc_i[1];
`else
      r_head_pc  <= {redirect_pc_i[31:2], 2'b00};
      r_skip_low <= 1'b0;
`endif
    end else begin
      if (w_push) begin
        if (r_skip_low) begin
          r_buf[r_wr_ptr] <= fetch_data_i[31:16];
          r_skip_low      <= 1'b0;
        end else begin
          r_buf[r_wr_ptr]    <= fetch_data_i[15:0];
          r_buf[w_wr_ptr_p1] <= fetch_data_i[31:16];
        end
        r_wr_ptr <= f_adv(r_wr_ptr, w_push_n);
      end
      if (w_pop) begin
        r_rd_ptr  <= f_adv(r_rd_ptr, w_pop_n);
        r_head_pc <= r_head_pc + (w_c ? 32'd2 : 32'd4);
      end
      r_count <= r_count + CW'(w_push_n) - CW'(w_pop_n);
    end
  end

  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n) r_count <= CW'(DEPTH));
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
                                  w_push |-> (r_count <= CW'(DEPTH - 2)));

endmodule

// File: tb/tb_inst_realign.sv
// Self-checking bench for inst_realign: directed scenarios plus randomized traffic,
// checked against a parcel-queue reference model. Honours REALIGN_RVC_EN like the DUT.
module tb_inst_realign;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef REALIGN_RVC_EN
  localparam bit RVC = 1'b1;
`else
  localparam bit RVC = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        flush_i;
  logic [31:0] redirect_pc_i;
  logic        fetch_valid_i;
  logic        fetch_ready_o;
  logic [31:0] fetch_data_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        is_compressed_o;

  inst_realign #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush_i        (flush_i),
    .redirect_pc_i  (redirect_pc_i),
    .fetch_valid_i  (fetch_valid_i),
    .fetch_ready_o  (fetch_ready_o),
    .fetch_data_i   (fetch_data_i),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .inst_o         (inst_o),
    .inst_pc_o      (inst_pc_o),
    .is_compressed_o(is_compressed_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_err;

  // Reference model: FIFO of halfword parcels in address order.
  logic [15:0] mq[$];
  logic [31:0] m_pc;
  bit          m_skip;

  function automatic bit m_c();
    if (mq.size() == 0) return 1'b0;
    return RVC && (mq[0][1:0] != 2'b11);
  endfunction

  function automatic bit m_valid();
    if (mq.size() == 0) return 1'b0;
    if (m_c()) return 1'b1;
    return mq.size() >= 2;
  endfunction

  function automatic logic [31:0] m_inst();
    if (m_c()) return {16'h0000, mq[0]};
    return {mq[1], mq[0]};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_pc   = RESET_PC;
    m_skip = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_check();
    chk("out_valid", out_valid_o, m_valid());
    chk("fetch_ready", fetch_ready_o, mq.size() <= DEPTH - 2);
    if (m_valid()) begin
      chk("inst", inst_o, m_inst());
      chk("inst_pc", inst_pc_o, m_pc);
      chk("is_compressed", is_compressed_o, m_c());
    end
  endtask

  task automatic model_update();
    bit rdy;
    if (flush_i) begin
      mq.delete();
      if (RVC) begin
        m_pc   = {redirect_pc_i[31:1], 1'b0};
        m_skip = redirect_pc_i[1];
      end else begin
        m_pc   = {redirect_pc_i[31:2], 2'b00};
        m_skip = 1'b0;
      end
    end else begin
      rdy = (mq.size() <= DEPTH - 2);
      if (m_valid() && out_ready_i) begin
        if (m_c()) begin
          void'(mq.pop_front());
          m_pc = m_pc + 32'd2;
        end else begin
          void'(mq.pop_front());
          void'(mq.pop_front());
          m_pc = m_pc + 32'd4;
        end
      end
      if (fetch_valid_i && rdy) begin
        if (m_skip) begin
          mq.push_back(fetch_data_i[31:16]);
          m_skip = 1'b0;
        end else begin
          mq.push_back(fetch_data_i[15:0]);
          mq.push_back(fetch_data_i[31:16]);
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_check();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] d);
    fetch_valid_i = 1'b1;
    fetch_data_i  = d;
    step();
    fetch_valid_i = 1'b0;
  endtask

  task automatic flush_to(input logic [31:0] pc);
    flush_i       = 1'b1;
    redirect_pc_i = pc;
    step();
    flush_i       = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] inst,
                            input logic [31:0] pc, input logic c);
    chk({tag, "_valid"}, out_valid_o, 1'b1);
    chk({tag, "_inst"}, inst_o, inst);
    chk({tag, "_pc"}, inst_pc_o, pc);
    chk({tag, "_c"}, is_compressed_o, c);
  endtask

  task automatic expect_idle(input string tag);
    chk({tag, "_valid"}, out_valid_o, 1'b0);
  endtask

  initial begin
    n_cmp         = 0;
    n_err         = 0;
    rst_n         = 1'b0;
    flush_i       = 1'b0;
    redirect_pc_i = '0;
    fetch_valid_i = 1'b0;
    fetch_data_i  = '0;
    out_ready_i   = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid_o, 1'b0);
    chk("rst_ready", fetch_ready_o, 1'b1);
    chk("rst_inst", inst_o, 32'h0);
    chk("rst_c", is_compressed_o, 1'b0);
    chk("rst_pc", inst_pc_o, RESET_PC);
    rst_n = 1'b1;

    // Single aligned 32-bit instruction
    out_ready_i = 1'b1;
    push_word(32'h0001_0113);
    expect_out("t1_addi", 32'h0001_0113, 32'h0, 1'b0);
    step();
    expect_idle("t1_drained");

    // Two compressed instructions in one word
    push_word(32'h4501_4505);
`ifdef REALIGN_RVC_EN
    expect_out("t2_cli0", 32'h0000_4505, 32'h4, 1'b1);
    step();
    expect_out("t2_cli1", 32'h0000_4501, 32'h6, 1'b1);
`else
    expect_out("t2_word", 32'h4501_4505, 32'h4, 1'b0);
`endif
    step();
    expect_idle("t2_drained");

    // 32-bit instruction straddling two fetch words
    flush_to(32'h0);
    push_word(32'h0113_4505);
`ifdef REALIGN_RVC_EN
    expect_out("t3_cli", 32'h0000_4505, 32'h0, 1'b1);
    step();
    expect_idle("t3_wait0");
    step();
    expect_idle("t3_wait1");
    push_word(32'h0000_0001);
    expect_out("t3_straddle", 32'h0001_0113, 32'h2, 1'b0);
`else
    expect_out("t3_word", 32'h0113_4505, 32'h0, 1'b0);
    step();
    expect_idle("t3_wait0");
    push_word(32'h0000_0001);
    expect_out("t3_next", 32'h0000_0001, 32'h4, 1'b0);
`endif
    repeat (3) step();

    // Backpressure until full, then drain
    flush_to(32'h0);
    out_ready_i = 1'b0;
    for (int k = 0; k < DEPTH / 2; k++) push_word(32'h0000_0013 | (32'(k + 1) << 20));
    chk("t4_full_ready", fetch_ready_o, 1'b0);
    expect_out("t4_head", 32'h0010_0013, 32'h0, 1'b0);
    push_word(32'hDEAD_BEEF);
    out_ready_i = 1'b1;
    step();
    chk("t4_ready_back", fetch_ready_o, 1'b1);
    expect_out("t4_second", 32'h0020_0013, 32'h4, 1'b0);
    repeat (DEPTH / 2) step();
    expect_idle("t4_drained");

    // Flush to a halfword target with parcels still buffered
    flush_to(32'h0);
    out_ready_i = 1'b0;
    push_word(32'h4501_4505);
    out_ready_i = 1'b1;
    push_word(32'h0113_4505);
    flush_to(32'h0000_0102);
    expect_idle("t5_flushed");
    push_word(32'h4505_1234);
`ifdef REALIGN_RVC_EN
    expect_out("t5_target", 32'h0000_4505, 32'h0000_0102, 1'b1);
`else
    expect_out("t5_target", 32'h4505_1234, 32'h0000_0100, 1'b0);
`endif
    repeat (2) step();

    // PC wraps modulo 2^32
    flush_to(32'hFFFF_FFFC);
    push_word(32'h0001_0113);
    push_word(32'h0002_0193);
    expect_out("wrap_pc", 32'h0002_0193, 32'h0, 1'b0);
    repeat (2) step();

    // Asynchronous reset with a partially received instruction buffered
    flush_to(32'h0000_0200);
    out_ready_i = 1'b0;
    push_word(32'h0113_4505);
`ifdef REALIGN_RVC_EN
    out_ready_i = 1'b1;
    step();
    out_ready_i = 1'b0;
    expect_idle("t6_straddle_wait");
`endif
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("t6_rst_valid", out_valid_o, 1'b0);
    chk("t6_rst_ready", fetch_ready_o, 1'b1);
    chk("t6_rst_pc", inst_pc_o, RESET_PC);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Randomized traffic with occasional redirects
    for (int i = 0; i < 600; i++) begin
      fetch_valid_i = ($urandom_range(0, 3) != 0);
      fetch_data_i  = $urandom;
      out_ready_i   = ($urandom_range(0, 2) != 0);
      flush_i       = ($urandom_range(0, 31) == 0);
      redirect_pc_i = $urandom;
      step();
    end
    fetch_valid_i = 1'b0;
    flush_i       = 1'b0;
    out_ready_i   = 1'b1;
    repeat (DEPTH + 1) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
